// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state type and line sizing helper for the memory line server
package mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} mem_state_t;

  function automatic int line_words(input int offset_width);
    return 2 ** (offset_width - 2);
  endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - word-wide backing store with async read, sync write and sync clear
module mem_array #(
  parameter int DEPTH_WIDTH = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   we_i,
  input  logic [DEPTH_WIDTH-1:0] addr_i,
  input  logic [31:0]            wdata_i,
  output logic [31:0]            rdata_o
);

  logic [31:0] store_q [2**DEPTH_WIDTH];

  // The clear happens in a single cycle so read data is never X after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2**DEPTH_WIDTH; i++) begin
        store_q[i] <= '0;
      end
    end else if (we_i) begin
      store_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = store_q[addr_i];

endmodule

// File: rtl/mem_line_server.sv
// rtl/mem_line_server.sv - line-granular fill/write-back responder: FSM, counters, address generation
`ifndef CACHE_B
`define CACHE_B 4
`endif

module mem_line_server
  import mem_pkg::*;
#(
  parameter int OFFSET_WIDTH = `CACHE_B,
  parameter int DEPTH_WIDTH  = 10,
  parameter int LATENCY      = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] write_data_i,
  output logic        ready_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] read_data_o,
  output logic        data_valid_o,
  output logic        done_o
);

  localparam int LW    = line_words(OFFSET_WIDTH);
  localparam int CNT_W = OFFSET_WIDTH - 2;
  localparam int LAT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  mem_state_t                state_q, state_d;
  logic [LAT_W-1:0]          lat_q, lat_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [31:OFFSET_WIDTH]    base_q, base_d;
  logic                      write_q, write_d;
  logic [31:0]               last_addr_q;
  logic [31:0]               xfer_addr;
  logic                      unused_addr_bits;

  assign unused_addr_bits = ^req_addr_i[OFFSET_WIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      cnt_q       <= '0;
      base_q      <= '0;
      write_q     <= 1'b0;
      last_addr_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      write_q <= write_d;
      if (state_q == XFER) begin
        last_addr_q <= xfer_addr;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    write_d = write_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          base_d  = req_addr_i[31:OFFSET_WIDTH];
          write_d = req_write_i;
          lat_d   = LAT_W'(LATENCY);
          state_d = (LATENCY == 0) ? XFER : WAIT;
        end
      end
      WAIT: begin
        if (lat_q == LAT_W'(1)) begin
          state_d = XFER;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      XFER: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LW - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign xfer_addr    = {base_q, cnt_q, 2'b00};
  assign mem_addr_o   = (state_q == XFER) ? xfer_addr : last_addr_q;
  assign ready_o      = (state_q == IDLE);
  assign data_valid_o = (state_q == XFER);
  assign done_o       = (state_q == DONE);

  mem_array #(
    .DEPTH_WIDTH(DEPTH_WIDTH)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    ((state_q == XFER) && write_q),
    .addr_i  (mem_addr_o[DEPTH_WIDTH+1:2]),
    .wdata_i (write_data_i),
    .rdata_o (read_data_o)
  );

endmodule

// File: tb/tb_mem_line_server.sv
// tb/tb_mem_line_server.sv - self-checking bench for mem_line_server (LATENCY 4 and 0 instances)
module tb_mem_line_server;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, req_write, sel0;
  logic [31:0] req_addr, write_data;
  logic        req_a, req_b;
  logic        ready_a, valid_a, done_a, ready_b, valid_b, done_b;
  logic [31:0] addr_a, rdata_a, addr_b, rdata_b;
  logic        m_ready, m_valid, m_done;
  logic [31:0] m_addr, m_rdata;

  assign req_a   = req & ~sel0;
  assign req_b   = req & sel0;
  assign m_ready = sel0 ? ready_b : ready_a;
  assign m_valid = sel0 ? valid_b : valid_a;
  assign m_done  = sel0 ? done_b  : done_a;
  assign m_addr  = sel0 ? addr_b  : addr_a;
  assign m_rdata = sel0 ? rdata_b : rdata_a;

  mem_line_server #(.OFFSET_WIDTH(4), .DEPTH_WIDTH(10), .LATENCY(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .req_write_i(req_write),
    .req_addr_i(req_addr), .write_data_i(write_data), .ready_o(ready_a),
    .mem_addr_o(addr_a), .read_data_o(rdata_a), .data_valid_o(valid_a), .done_o(done_a));

  mem_line_server #(.OFFSET_WIDTH(4), .DEPTH_WIDTH(10), .LATENCY(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .req_write_i(req_write),
    .req_addr_i(req_addr), .write_data_i(write_data), .ready_o(ready_b),
    .mem_addr_o(addr_b), .read_data_o(rdata_b), .data_valid_o(valid_b), .done_o(done_b));

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] model_a [1024];
  logic [31:0] model_b [1024];

  function automatic logic [31:0] model_rd(input logic s, input logic [31:0] a);
    return s ? model_b[a[11:2]] : model_a[a[11:2]];
  endfunction

  task automatic model_wr(input logic s, input logic [31:0] a, input logic [31:0] d);
    if (s) model_b[a[11:2]] = d;
    else   model_a[a[11:2]] = d;
  endtask

  task automatic clear_models();
    for (int i = 0; i < 1024; i++) begin
      model_a[i] = '0;
      model_b[i] = '0;
    end
  endtask

  task automatic apply_reset(input int ncyc);
    @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    repeat (ncyc) @(negedge clk);
    rst = 1'b0;
    clear_models();
  endtask

  // Compare one observed transfer word against the scoreboard head.
  task automatic check_word(input string name, input logic wr);
    logic [31:0] ea, ed;
    checks++;
    if (exp_addr_q.size() == 0) begin
      failures++;
      $display("FAIL %s extra_word addr=%h", name, m_addr);
    end else begin
      ea = exp_addr_q.pop_front();
      ed = exp_data_q.pop_front();
      if (m_addr !== ea) begin
        failures++;
        $display("FAIL %s mem_addr got=%h exp=%h", name, m_addr, ea);
      end
      if (wr) begin
        write_data = ed;
      end else begin
        checks++;
        if (m_rdata !== ed) begin
          failures++;
          $display("FAIL %s read_data@%h got=%h exp=%h", name, ea, m_rdata, ed);
        end
      end
    end
  endtask

  task automatic burst(input logic wr, input logic [31:0] addr, input logic [31:0] d0, input string name);
    int lat, first_v, nvalid, done_cyc;
    logic [31:0] base;
    lat = sel0 ? 0 : 4;
    first_v = -1; nvalid = 0; done_cyc = -1;
    base = {addr[31:4], 4'h0};
    for (int i = 0; i < 4; i++) begin
      exp_addr_q.push_back(base + 32'(4 * i));
      if (wr) begin
        exp_data_q.push_back(d0 + 32'(i));
        model_wr(sel0, base + 32'(4 * i), d0 + 32'(i));
      end else begin
        exp_data_q.push_back(model_rd(sel0, base + 32'(4 * i)));
      end
    end
    @(negedge clk);
    checks++;
    if (m_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before got=%b exp=1", name, m_ready);
    end
    req = 1'b1; req_write = wr; req_addr = addr;
    for (int cyc = 1; cyc <= 30 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) req = 1'b0;
      if (m_valid === 1'b1) begin
        if (first_v < 0) first_v = cyc;
        nvalid++;
        check_word(name, wr);
      end
      if (m_done === 1'b1) begin
        done_cyc = cyc;
        checks++;
        if (m_ready !== 1'b0) begin
          failures++;
          $display("FAIL %s ready_in_done got=%b exp=0", name, m_ready);
        end
      end
    end
    checks++;
    if (first_v != lat + 1 || nvalid != 4 || done_cyc != lat + 5) begin
      failures++;
      $display("FAIL %s timing first_valid=%0d words=%0d done=%0d exp=%0d/4/%0d",
               name, first_v, nvalid, done_cyc, lat + 1, lat + 5);
    end
    @(negedge clk);
    checks++;
    if (m_ready !== 1'b1 || exp_addr_q.size() != 0) begin
      failures++;
      $display("FAIL %s ready_after got=%b leftover=%0d exp=1/0", name, m_ready, exp_addr_q.size());
    end
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  task automatic test_reset();
    apply_reset(2);
    checks++;
    if (ready_a !== 1'b1 || done_a !== 1'b0 || valid_a !== 1'b0 || addr_a !== 32'h0 || ready_b !== 1'b1) begin
      failures++;
      $display("FAIL reset_state ready=%b done=%b valid=%b addr=%h ready0=%b exp=1/0/0/0/1",
               ready_a, done_a, valid_a, addr_a, ready_b);
    end
    rst = 1'b1; req = 1'b1; req_write = 1'b0; req_addr = 32'h40;
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ready_a !== 1'b1 || valid_a !== 1'b0) begin
        failures++;
        $display("FAIL reset_wins ready=%b valid=%b exp=1/0", ready_a, valid_a);
      end
    end
  endtask

  task automatic test_held_req();
    int nvalid;
    nvalid = 0;
    for (int i = 0; i < 4; i++) begin
      exp_addr_q.push_back(32'h80 + 32'(4 * i));
      exp_data_q.push_back(model_rd(1'b0, 32'h80 + 32'(4 * i)));
    end
    @(negedge clk);
    req = 1'b1; req_write = 1'b0; req_addr = 32'h80;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      @(negedge clk);
      if (m_valid === 1'b1) begin
        nvalid++;
        check_word("held_req", 1'b0);
      end
      checks++;
      if (cyc <= 9 && m_ready !== 1'b0) begin
        failures++;
        $display("FAIL held_req ready@%0d got=%b exp=0", cyc, m_ready);
      end else if (cyc >= 10 && m_ready !== 1'b1) begin
        failures++;
        $display("FAIL held_req ready@%0d got=%b exp=1", cyc, m_ready);
      end
      if (cyc == 10) req = 1'b0;
    end
    checks++;
    if (nvalid != 4) begin
      failures++;
      $display("FAIL held_req words got=%0d exp=4", nvalid);
    end
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  task automatic test_mid_reset();
    logic saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    req = 1'b1; req_write = 1'b1; req_addr = 32'h200;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (cyc == 1) req = 1'b0;
      if (m_valid === 1'b1) write_data = 32'hD0 + 32'(cyc);
      if (cyc == 5 || cyc == 6) begin
        checks++;
        if (m_valid !== 1'b1 || m_addr !== 32'h200 + 32'(4 * (cyc - 5))) begin
          failures++;
          $display("FAIL mid_reset xfer@%0d valid=%b addr=%h", cyc, m_valid, m_addr);
        end
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_models();
    checks++;
    if (m_ready !== 1'b1 || m_valid !== 1'b0 || m_done !== 1'b0 || m_addr !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset state ready=%b valid=%b done=%b addr=%h exp=1/0/0/0",
               m_ready, m_valid, m_done, m_addr);
    end
    repeat (10) begin
      @(negedge clk);
      if (m_done === 1'b1 || m_valid === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL mid_reset activity_after_abort got=1 exp=0");
    end
    burst(1'b0, 32'h200, 32'h0, "mid_reset_fill_200");
    burst(1'b0, 32'h80, 32'h0, "mid_reset_fill_80");
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; req_write = 1'b0; req_addr = '0; write_data = '0; sel0 = 1'b0;
    clear_models();
    test_reset();
    burst(1'b0, 32'h40, 32'h0, "fill_zero_40");
    burst(1'b1, 32'h80, 32'hA0, "wb_80");
    burst(1'b0, 32'h8C, 32'h0, "fill_unaligned_8c");
    test_held_req();
    sel0 = 1'b1;
    burst(1'b0, 32'h40, 32'h0, "lat0_fill_40");
    burst(1'b1, 32'h100, 32'hC0, "lat0_wb_100");
    burst(1'b0, 32'h104, 32'h0, "lat0_fill_104");
    sel0 = 1'b0;
    burst(1'b1, 32'h1000, 32'hB0, "alias_wb_1000");
    burst(1'b0, 32'h0, 32'h0, "alias_fill_0");
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
